// File: rtl/mitchell_pkg.sv
// mitchell_pkg: shared widths, log-word type and reference antilog function
package mitchell_pkg;
  localparam int KW = 4;
  localparam int FW = 8;
  localparam int PW = 16;
  typedef struct packed {
    logic          zero;
    logic [KW-1:0] k;
    logic [FW-1:0] f;
  } log_word_t;
  function automatic logic [PW-1:0] antilog_ref(input logic [KW-1:0] k, input logic [FW-1:0] f, input logic zero);
    logic [FW+PW-1:0] m;
    m = (FW+PW)'({1'b1, f}) << k;
    return zero ? '0 : PW'(m >> FW);
  endfunction
endpackage

// File: rtl/antilog_shifter.sv
// antilog_shifter: combinational log-depth barrel shift of {1,f} by k, keeping the integer part
module antilog_shifter #(
  parameter int KW = 4,
  parameter int FW = 8,
  parameter int PW = 16
) (
  input  logic [KW-1:0] k,
  input  logic [FW-1:0] f,
  input  logic          zero,
  output logic [PW-1:0] p
);
  import mitchell_pkg::*;
  localparam int SW = FW + PW;
  logic [KW:0][SW-1:0] s;
  assign s[0] = SW'({1'b1, f});
  for (genvar i = 0; i < KW; i++) begin : g_lvl
    assign s[i+1] = k[i] ? s[i] << (1 << i) : s[i];
  end
  assign p = zero ? '0 : PW'(s[KW] >> FW);
endmodule

// File: rtl/mitchell_antilog.sv
// mitchell_antilog: 2-stage valid/ready pipeline decoding (k, f) to a linear product
module mitchell_antilog #(
  parameter int KW = mitchell_pkg::KW,
  parameter int FW = mitchell_pkg::FW,
  parameter int PW = mitchell_pkg::PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [KW-1:0] in_k,
  input  logic [FW-1:0] in_f,
  input  logic          in_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_p
);
  import mitchell_pkg::*;
  if (PW != (1 << KW)) begin : g_bad_pw
    $error("mitchell_antilog: PW must equal 2**KW");
  end
  logic          s1_valid;
  logic [KW-1:0] s1_k;
  logic [FW-1:0] s1_f;
  logic          s1_zero;
  logic [PW-1:0] p_next;
  logic          s1_load;
  logic          s2_load;
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !rst && (!s1_valid || s2_load);
  assign s1_load  = in_valid && in_ready;
  antilog_shifter #(.KW(KW), .FW(FW), .PW(PW)) u_shift (
    .k    (s1_k),
    .f    (s1_f),
    .zero (s1_zero),
    .p    (p_next)
  );
  // Stage registers and valid tracking; S2 holds its word while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_k      <= '0;
      s1_f      <= '0;
      s1_zero   <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else begin
      if (s1_load) begin
        s1_k    <= in_k;
        s1_f    <= in_f;
        s1_zero <= in_zero;
      end
      if (s2_load) out_p <= p_next;
      s1_valid  <= s1_load || (s1_valid && !s2_load);
      out_valid <= s2_load || (out_valid && !out_ready);
    end
  end
  if (KW == mitchell_pkg::KW && FW == mitchell_pkg::FW && PW == mitchell_pkg::PW) begin : g_chk
    // Shifter result must agree with the reference decode whenever it is captured
    always_ff @(posedge clk) begin
      if (!rst && s2_load) assert (p_next == antilog_ref(s1_k, s1_f, s1_zero));
    end
  end
endmodule

// File: tb/tb_mitchell_antilog.sv
// tb_mitchell_antilog: directed and randomized handshake checks against a reference scoreboard
module tb_mitchell_antilog;
  import mitchell_pkg::*;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [KW-1:0] in_k = '0;
  logic [FW-1:0] in_f = '0;
  logic          in_zero = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] out_p;
  int errors = 0;
  int checks = 0;
  int in_cnt = 0;
  int out_cnt = 0;
  logic [PW-1:0] q[$];
  logic          hold = 1'b0;
  logic [PW-1:0] hold_p = '0;

  mitchell_antilog dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_k      (in_k),
    .in_f      (in_f),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [KW-1:0] k, input logic [FW-1:0] f, input logic z, input logic [PW-1:0] exp);
    in_k = k;
    in_f = f;
    in_zero = z;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_valid_early", 32'(out_valid), 0);
    tick();
    chk("lat_valid", 32'(out_valid), 1);
    chk("direct_p", 32'(out_p), 32'(exp));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold) chk("stall_hold", 32'(out_p), 32'(hold_p));
      if (out_valid && out_ready) begin
        out_cnt++;
        if (q.size() == 0) chk("sb_unexpected", 32'(out_p), 32'hffff_ffff);
        else chk("sb_p", 32'(out_p), 32'(q.pop_front()));
      end
      if (in_valid && in_ready) begin
        in_cnt++;
        q.push_back(antilog_ref(in_k, in_f, in_zero));
      end
      hold = out_valid && !out_ready;
      hold_p = out_p;
    end
  end

  initial begin
    int base_in, base_out;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_p", 32'(out_p), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("release_in_ready", 32'(in_ready), 1);
    send(4'd0, 8'd0, 1'b0, 16'd1);
    send(4'd3, 8'd128, 1'b0, 16'd12);
    send(4'd7, 8'd64, 1'b0, 16'd160);
    send(4'd15, 8'd255, 1'b0, 16'd65408);
    send(4'd9, 8'd17, 1'b1, 16'd0);
    tick();
    base_in = in_cnt;
    base_out = out_cnt;
    for (int i = 0; i < 100; i++) begin
      in_k = KW'($urandom);
      in_f = FW'($urandom);
      in_zero = ($urandom_range(0, 9) == 0);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    chk("stream_in", 32'(in_cnt - base_in), 100);
    chk("stream_out", 32'(out_cnt - base_out), 100);
    out_ready = 1'b0;
    base_in = in_cnt;
    for (int i = 0; i < 5; i++) begin
      in_k = KW'(i + 2);
      in_f = FW'(i * 37 + 5);
      in_zero = 1'b0;
      in_valid = 1'b1;
      tick();
    end
    chk("stall_accepted", 32'(in_cnt - base_in), 2);
    chk("stall_in_ready", 32'(in_ready), 0);
    chk("stall_out_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(in_ready), 1);
    base_out = out_cnt;
    repeat (3) tick();
    chk("drain_out", 32'(out_cnt - base_out), 2);
    chk("drain_empty", 32'(q.size()), 0);
    for (int i = 0; i < 2000; i++) begin
      in_k = KW'($urandom);
      in_f = FW'($urandom);
      in_zero = ($urandom_range(0, 15) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rand_balance", 32'(in_cnt), 32'(out_cnt));
    chk("rand_empty", 32'(q.size()), 0);
    chk("rand_out_valid", 32'(out_valid), 0);
    out_ready = 1'b0;
    in_k = 4'd5;
    in_f = 8'd99;
    in_zero = 1'b0;
    in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    chk("inflight_two", 32'(q.size()), 2);
    base_out = out_cnt;
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_no_xfer", 32'(out_cnt), 32'(base_out));
    rst = 1'b0;
    send(4'd4, 8'd0, 1'b0, 16'd16);
    tick();
    chk("final_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
